// File: rtl/sqrt_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_sched_pkg
// Purpose  : Shared types, default sizes and index-width helper for sqrt_sched
// Revision : 1.0 - initial release
// ============================================================================
package sqrt_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RESP   = 3'd3,
    ST_ABORT  = 3'd4
  } state_e;

  localparam int unsigned C_DEF_N_REQ   = 4;
  localparam int unsigned C_DEF_WIDTH   = 16;
  localparam int unsigned C_DEF_TIMEOUT = 64;

  // Index width for a range of n values, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : unsigned'($clog2(n));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sqrt_sched_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick of the first request at/after ptr
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import sqrt_sched_pkg::*;
#(
  parameter int unsigned N_REQ = C_DEF_N_REQ,
  parameter int unsigned IDX_W = idx_w(C_DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt,
  output logic             any
);

  logic [IDX_W:0] cand;

  // Scan offsets from far to near so the nearest asserted index is written last.
  always_comb begin
    gnt  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (req[cand[IDX_W-1:0]]) begin
        gnt = cand[IDX_W-1:0];
        any = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sqrt_sched.sv
`default_nettype none
// ============================================================================
// Module   : sqrt_sched
// Purpose  : Round-robin scheduler sharing one sqrt core among N_REQ requesters
// Revision : 1.0 - initial release
// ============================================================================
module sqrt_sched
  import sqrt_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = C_DEF_N_REQ,
  parameter int unsigned WIDTH   = C_DEF_WIDTH,
  parameter int unsigned TIMEOUT = C_DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  output logic [N_REQ-1:0]         req_ack,
  output logic                     resp_valid,
  output logic [idx_w(N_REQ)-1:0]  resp_id,
  output logic [WIDTH-1:0]         resp_data,
  output logic                     resp_err,
  output logic                     busy,
  output logic                     core_init,
  output logic [WIDTH-1:0]         core_a,
  output logic                     core_rst,
  input  logic [WIDTH-1:0]         core_result,
  input  logic                     core_done
);

  localparam int unsigned      IDX_W      = idx_w(N_REQ);
  localparam int unsigned      WD_W       = idx_w(TIMEOUT);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [WD_W-1:0]  C_WD_LIMIT = WD_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0] core_a_q, core_a_d;
  logic [IDX_W-1:0] resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             resp_err_q, resp_err_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             done_q, done_d;

  logic [IDX_W-1:0] arb_gnt;
  logic             arb_any;
  logic             done_rise;
  logic             wd_expired;
  logic [IDX_W-1:0] gnt_next;
  logic [WIDTH-1:0] req_ops [N_REQ];

  for (genvar i = 0; i < int'(N_REQ); i++) begin : g_ops
    assign req_ops[i] = req_a[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .any (arb_any)
  );

  // Only a low-to-high transition counts, so a done level left high by the
  // previous operation cannot complete the current one.
  assign done_rise  = core_done & ~done_q;
  assign wd_expired = (wd_q == C_WD_LIMIT);
  assign gnt_next   = (gnt_q == C_LAST_IDX) ? '0 : gnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      core_a_q    <= '0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      wd_q        <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      core_a_q    <= core_a_d;
      resp_id_q   <= resp_id_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      wd_q        <= wd_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    core_a_d    = core_a_q;
    resp_id_d   = resp_id_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    wd_d        = wd_q;
    done_d      = core_done;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          gnt_d    = arb_gnt;
          core_a_d = req_ops[arb_gnt];
          state_d  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wd_q != '1) begin
          wd_d = wd_q + 1'b1;
        end
        if (done_rise) begin
          resp_id_d   = gnt_q;
          resp_data_d = core_result;
          resp_err_d  = 1'b0;
          state_d     = ST_RESP;
        end else if (wd_expired) begin
          resp_id_d   = gnt_q;
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          state_d     = ST_ABORT;
        end
      end
      ST_RESP, ST_ABORT: begin
        ptr_d   = gnt_next;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ack    = '0;
    core_init  = 1'b0;
    resp_valid = 1'b0;
    busy       = (state_q != ST_IDLE);
    core_rst   = rst;
    case (state_q)
      ST_LAUNCH: begin
        core_init       = 1'b1;
        req_ack[gnt_q]  = 1'b1;
      end
      ST_RESP: resp_valid = 1'b1;
      ST_ABORT: begin
        resp_valid = 1'b1;
        core_rst   = 1'b1;
      end
      default: ;
    endcase
  end

  assign core_a    = core_a_q;
  assign resp_id   = resp_id_q;
  assign resp_data = resp_data_q;
  assign resp_err  = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sqrt_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sqrt_sched
// Purpose  : Self-checking bench for sqrt_sched with a stub sqrt core
// Revision : 1.0 - initial release
// ============================================================================
module tb_sqrt_sched;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N-1:0]   req_ack;
  logic           resp_valid;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_data;
  logic           resp_err;
  logic           busy;
  logic           core_init;
  logic [W-1:0]   core_a;
  logic           core_rst;
  logic [W-1:0]   core_result = '0;
  logic           core_done = 1'b0;

  always #5 clk = ~clk;

  sqrt_sched #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a),
    .req_ack(req_ack), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
    .core_init(core_init), .core_a(core_a), .core_rst(core_rst),
    .core_result(core_result), .core_done(core_done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // stimulus plan applied each cycle
  logic [N-1:0] p_req = '0;
  logic [W-1:0] p_a [N];
  bit           p_keep = 1'b0;
  bit           p_rst  = 1'b1;

  // stub sqrt core: 0 normal, 1 never done, 2 holds old done high after init
  int           c_mode = 0;
  bit           c_done = 1'b0;
  logic [W-1:0] c_res = '0;
  logic [W-1:0] c_a = '0;
  int           c_cnt = 0;
  int           c_hold = 0;

  // reference model: one operation record plus round-robin pointer
  bit           m_active = 1'b0;
  int           m_gnt = 0, m_launch = 0, m_resp = -1, m_ptr = 0, m_id = 0;
  logic [W-1:0] m_core_a = '0, m_data = '0;
  bit           m_err = 1'b0, m_prev_done = 1'b0;

  int n_ack = 0, n_init = 0, n_resp = 0, n_crst = 0;
  int last_ack_cyc = 0, last_resp_cyc = 0;
  int           ids[$];
  logic [W-1:0] datas[$];
  bit           errs[$];

  function automatic int isqrt(input int a);
    int r = 0;
    while ((r + 1) * (r + 1) <= a) r++;
    return r;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    if (p_rst) begin
      m_active = 1'b0; m_ptr = 0; m_core_a = '0; m_id = 0;
      m_data = '0; m_err = 1'b0; m_prev_done = 1'b0;
    end else begin
      if (!m_active) begin
        if (p_req != '0) begin
          m_gnt = rr_pick(p_req, m_ptr);
          m_active = 1'b1; m_launch = cyc + 1; m_resp = -1;
          m_core_a = p_a[m_gnt];
        end
      end else if (cyc == m_resp) begin
        m_active = 1'b0;
        m_ptr = (m_gnt + 1) % N;
      end else if (m_resp < 0 && cyc > m_launch) begin
        if (c_done && !m_prev_done) begin
          m_resp = cyc + 1; m_id = m_gnt; m_err = 1'b0;
          m_data = W'(isqrt(int'(m_core_a)));
        end else if (cyc == m_launch + TO) begin
          m_resp = cyc + 1; m_id = m_gnt; m_err = 1'b1; m_data = '0;
        end
      end
      m_prev_done = c_done;
    end
  endtask

  task automatic core_step();
    if (core_rst === 1'b1) begin
      c_done = 1'b0; c_cnt = 0; c_hold = 0;
    end else if (core_init === 1'b1) begin
      c_a = core_a;
      if (c_mode == 1) begin
        c_done = 1'b0; c_cnt = 0; c_hold = 0;
      end else if (c_mode == 2 && c_done) begin
        c_hold = $urandom_range(3, 1); c_cnt = 0;
      end else begin
        c_done = 1'b0; c_hold = 0; c_cnt = $urandom_range(5, 1);
      end
    end else if (c_hold > 0) begin
      c_hold--;
      if (c_hold == 0) begin
        c_done = 1'b0; c_cnt = $urandom_range(4, 1);
      end
    end else if (c_cnt > 0) begin
      c_cnt--;
      if (c_cnt == 0) begin
        c_done = 1'b1;
        c_res  = W'(isqrt(int'(c_a)));
      end
    end
  endtask

  // One clock cycle: apply inputs, compare all outputs, advance core and model.
  task automatic step();
    logic [N-1:0] e_ack;
    bit e_launch, e_resp;
    @(negedge clk);
    rst = p_rst;
    req_valid = p_req;
    for (int i = 0; i < N; i++) req_a[i*W +: W] = p_a[i];
    core_done = c_done;
    core_result = c_res;
    #1;
    e_launch = m_active && (cyc == m_launch);
    e_resp   = m_active && (cyc == m_resp);
    e_ack    = e_launch ? (N'(1) << m_gnt) : '0;
    if (chk_en) begin
      chk("req_ack",    32'(req_ack),    32'(e_ack));
      chk("core_init",  32'(core_init),  32'(e_launch));
      chk("resp_valid", 32'(resp_valid), 32'(e_resp));
      chk("busy",       32'(busy),       32'(m_active));
      chk("core_rst",   32'(core_rst),   32'(p_rst | (e_resp & m_err)));
      chk("core_a",     32'(core_a),     32'(m_core_a));
      chk("resp_id",    32'(resp_id),    32'(m_id));
      chk("resp_data",  32'(resp_data),  32'(m_data));
      chk("resp_err",   32'(resp_err),   32'(m_err));
    end
    if (req_ack != '0) begin n_ack++; last_ack_cyc = cyc; end
    if (core_init === 1'b1) n_init++;
    if (core_rst === 1'b1 && !p_rst) n_crst++;
    if (resp_valid === 1'b1) begin
      n_resp++; last_resp_cyc = cyc;
      ids.push_back(int'(resp_id)); datas.push_back(resp_data); errs.push_back(resp_err);
    end
    model_step();
    core_step();
    for (int i = 0; i < N; i++) begin
      if (req_ack[i] === 1'b1 && !p_keep) p_req[i] = 1'b0;
    end
    cyc++;
  endtask

  task automatic run_resp(input int k, input int maxc, input string name);
    int target = n_resp + k;
    for (int j = 0; j < maxc && n_resp < target; j++) step();
    chk(name, 32'(n_resp), 32'(target));
  endtask

  task automatic do_reset();
    p_rst = 1'b1; p_req = '0; p_keep = 1'b0;
    step();
    p_rst = 1'b0;
    step();
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_id",   32'(resp_id),   32'd0);
    chk("rst_core_a",    32'(core_a),    32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int a0, i0, cr0, base, gap;
    for (int i = 0; i < N; i++) p_a[i] = '0;
    step();
    chk_en = 1'b1;

    // single request from requester 0
    do_reset();
    c_mode = 0; a0 = n_ack; i0 = n_init;
    p_a[0] = 16'h0441; p_req = 4'b0001;
    run_resp(1, 40, "t1_wait");
    chk("t1_ack_cnt",  32'(n_ack - a0),  32'd1);
    chk("t1_init_cnt", 32'(n_init - i0), 32'd1);
    chk("t1_id",   32'(ids[$]),   32'd0);
    chk("t1_data", 32'(datas[$]), 32'h0021);
    chk("t1_err",  32'(errs[$]),  32'd0);

    // requesters 1 and 3 together from ptr=0, then ptr wrap check
    do_reset();
    p_a[1] = 16'h0051; p_a[3] = 16'h0090; p_req = 4'b1010;
    run_resp(2, 60, "t2_wait");
    chk("t2_first_id",    32'(ids[$-1]),   32'd1);
    chk("t2_second_id",   32'(ids[$]),     32'd3);
    chk("t2_first_data",  32'(datas[$-1]), 32'h0009);
    chk("t2_second_data", 32'(datas[$]),   32'h000C);
    p_a[0] = 16'h1234; p_a[3] = 16'h0400; p_req = 4'b1001;
    run_resp(1, 40, "t2b_wait");
    chk("t2_ptr_wrap_id", 32'(ids[$]), 32'd0);
    run_resp(1, 40, "t2c_wait");

    // all four held continuously
    do_reset();
    for (int i = 0; i < N; i++) p_a[i] = W'($urandom);
    base = ids.size(); p_keep = 1'b1; p_req = 4'hF;
    run_resp(8, 200, "t3_wait");
    p_keep = 1'b0; p_req = '0;
    for (int k = 0; k < 8; k++) chk("t3_seq", 32'(ids[base + k]), 32'(k % 4));
    for (int j = 0; j < 20 && busy !== 1'b0; j++) step();

    // core that never finishes
    do_reset();
    c_mode = 1; cr0 = n_crst;
    p_a[2] = 16'h0100; p_req = 4'b0100;
    run_resp(1, 40, "t4_wait");
    chk("t4_err",  32'(errs[$]),  32'd1);
    chk("t4_data", 32'(datas[$]), 32'd0);
    chk("t4_lat",  32'(last_resp_cyc - last_ack_cyc), 32'(TO + 1));
    chk("t4_crst_pulses", 32'(n_crst - cr0), 32'd1);
    step();
    chk("t4_busy_after", 32'(busy), 32'd0);

    // done level held high into the next operation
    do_reset();
    c_mode = 0; p_a[2] = 16'h0031; p_req = 4'b0100;
    run_resp(1, 40, "t5a_wait");
    c_mode = 2; p_a[2] = 16'h00A9; p_req = 4'b0100;
    run_resp(1, 40, "t5b_wait");
    gap = last_resp_cyc - last_ack_cyc;
    chk("t5_gap_ok", 32'(gap >= 4), 32'd1);
    chk("t5_data",   32'(datas[$]), 32'h000D);

    // reset during WAIT drops the operation
    do_reset();
    c_mode = 1; p_a[1] = 16'h0010; p_req = 4'b0010;
    for (int j = 0; j < 10 && n_ack == 0; j++) step();
    step(); step();
    p_rst = 1'b1; step(); p_rst = 1'b0;
    a0 = n_resp;
    for (int j = 0; j < 12; j++) step();
    chk("t6_no_resp", 32'(n_resp - a0), 32'd0);
    chk("t6_busy",    32'(busy),        32'd0);
    c_mode = 0; p_a[2] = 16'hFFFF; p_req = 4'b0100;
    run_resp(1, 40, "t6_wait");
    chk("t6_id",   32'(ids[$]),   32'd2);
    chk("t6_data", 32'(datas[$]), 32'h00FF);

    // randomized traffic, core behaviour and occasional reset
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) begin
        if ($urandom_range(9, 0) < 6) c_mode = 0;
        else c_mode = ($urandom_range(1, 0) == 1) ? 2 : 1;
      end
      for (int i = 0; i < N; i++) begin
        if (!p_req[i] && $urandom_range(5, 0) == 0) begin
          p_req[i] = 1'b1;
          p_a[i] = W'($urandom);
        end
      end
      p_rst = ($urandom_range(299, 0) == 0);
      step();
    end
    p_rst = 1'b0; p_req = '0;
    for (int j = 0; j < 40; j++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
